binary_frame_scheduler: RTL and testbench
=========================================

Name: binary_frame_scheduler

Overview:
Sequences the 1-bit binary frame buffer through repeated capture/serve cycles. It issues the capture trigger and waits for capture completion, then shares the buffer's single registered read port between two readers using round-robin arbitration. The two readers are the pattern matcher (port 0) and the debug/display readout (port 1). The block sits between the binary frame buffer and the downstream pattern-recognition consumers.

Parameters:
IMG_WIDTH, 640, frame width in pixels
IMG_HEIGHT, 480, frame height in pixels
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), read address width
CAP_TIMEOUT, 1000000, max cycles in WAIT_CAP before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a capture when IDLE
continuous  in  1  1 = re-capture automatically after every frame is released
rd_en  in  2  per-requester participation mask, sampled on entry to SERVE
cap_trigger  out  1  one-cycle pulse to frame buffer
cap_complete  in  1  one-cycle pulse from frame buffer
bram_read_addr  out  ADDR_W  address to frame buffer read port
bram_read_data  in  1  frame buffer registered read data
req  in  2  read request per requester
req_addr0  in  ADDR_W  requester 0 address
req_addr1  in  ADDR_W  requester 1 address
gnt  out  2  one-hot grant (combinational)
rvalid  out  2  one-hot read-data-valid, one cycle after grant
rdata  out  1  read data (bram_read_data passthrough)
done  in  2  pulse; requester finished with current frame
frame_ready  out  1  high while in SERVE
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky; cleared only by rst
frame_count  out  16  completed captures, wraps at 65535 -> 0

Behaviour:
- Reset (rst sampled high at posedge):
  - State = IDLE; all outputs 0; round-robin pointer = 0; done flags cleared.
  - Reset mid-operation aborts immediately; no further cap_trigger issued.
- IDLE -> TRIGGER on start. start outside IDLE is ignored.
- TRIGGER (1 cycle): cap_trigger = 1 -> WAIT_CAP. Timeout counter cleared.
- WAIT_CAP:
  - cap_complete -> SERVE, frame_count += 1.
  - Counter reaching CAP_TIMEOUT-1 with no complete -> timeout_err = 1, go to IDLE.
  - cap_complete seen outside WAIT_CAP is ignored.
- SERVE:
  - On entry, latch en_q = rd_en and clear the done flags.
  - Eligible requester i: req[i] & en_q[i] & !done_flag[i].
  - Grant is combinational, at most one bit set.
  - If both requesters are eligible, grant the one selected by the pointer. On any grant, the pointer moves to the other requester.
  - bram_read_addr = address of the granted requester. With no grant, it holds its last value.
  - rvalid[i] is registered: 1 in the cycle after gnt[i]. rdata = bram_read_data in that cycle.
  - done[i] & en_q[i] sets done_flag[i]. A same-cycle req[i] is still granted; it is the last read.
  - Exit when (done_flag | ~en_q) == 2'b11 (flags as updated this cycle). en_q = 0 exits after 1 cycle.
  - Exit goes to DRAIN.
- DRAIN (1 cycle): no grants. The final rvalid completes here.
  - continuous = 1 -> TRIGGER.
  - continuous = 0 -> IDLE.
- No grant is ever issued outside SERVE, so readers never see data from a frame mid-capture.
- gnt and rvalid are 0 in every state except SERVE/DRAIN as described.
- frame_ready = (state == SERVE).

Test Plan:
- Reset, start=1 one cycle -> cap_trigger pulses 2nd cycle after start; busy=1. cap_complete 20 cycles later -> frame_ready=1 next cycle, frame_count=1.
- SERVE, rd_en=2'b11, req=2'b11 held 4 cycles -> gnt alternates 01,10,01,10. rvalid follows one cycle later. rdata matches the preloaded bit at each address (addr 0 -> 1, addr 5 -> 0).
- SERVE, req0 only, addr 7 -> gnt=01, bram_read_addr=7, rvalid=01 next cycle. done=01 with rd_en=01 -> DRAIN next cycle, then IDLE (continuous=0); busy=0.
- continuous=1, both done -> DRAIN, then TRIGGER (cap_trigger pulse); frame_count increments on each completion.
- CAP_TIMEOUT=50, no cap_complete -> timeout_err=1 after 50 WAIT_CAP cycles; state IDLE; start re-triggers; timeout_err stays 1 until rst.
- rst asserted in SERVE with req=2'b11 -> gnt=0 and rvalid=0 next cycle, frame_count=0. start during WAIT_CAP produces no extra cap_trigger.

Source files
------------

// File: rtl/binary_frame_scheduler.sv
// Capture/serve sequencer for the 1-bit frame buffer: triggers a capture, waits for it,
// then time-shares the buffer's registered read port between two readers round-robin.
module binary_frame_scheduler #(
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT),
   parameter int CAP_TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic [1:0]        rd_en,
   output logic              cap_trigger,
   input  logic              cap_complete,
   output logic [ADDR_W-1:0] bram_read_addr,
   input  logic              bram_read_data,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic              rdata,
   input  logic [1:0]        done,
   output logic              frame_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic [15:0]       frame_count
);

   localparam int CNT_W = (CAP_TIMEOUT > 1) ? $clog2(CAP_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIGGER,
      S_WAIT_CAP,
      S_SERVE,
      S_DRAIN
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_en_q;
   logic [1:0]        r_done_flag;
   logic              r_ptr;
   logic [1:0]        r_rvalid;
   logic [ADDR_W-1:0] r_last_addr;
   logic              r_timeout_err;
   logic [15:0]       r_frame_count;

   logic [1:0]        w_elig;
   logic [1:0]        w_gnt;
   logic [1:0]        w_done_nxt;
   logic [ADDR_W-1:0] w_addr;
   logic              w_cnt_last;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      w_elig      = 2'b00;
      w_gnt       = 2'b00;
      w_addr      = r_last_addr;
      w_done_nxt  = r_done_flag | (done & r_en_q);
      w_cnt_last  = (r_cnt == CNT_LAST);
      w_state_nxt = r_state;

      if (r_state == S_SERVE) begin
         w_elig = req & r_en_q & ~r_done_flag;
      end

      // Pointer only breaks ties; a lone eligible reader always wins.
      unique case (w_elig)
         2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
         2'b01,
         2'b10:   w_gnt = w_elig;
         default: w_gnt = 2'b00;
      endcase

      if (w_gnt[0]) begin
         w_addr = req_addr0;
      end else if (w_gnt[1]) begin
         w_addr = req_addr1;
      end

      unique case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_TRIGGER;
         end
         S_TRIGGER: w_state_nxt = S_WAIT_CAP;
         S_WAIT_CAP: begin
            if (cap_complete)    w_state_nxt = S_SERVE;
            else if (w_cnt_last) w_state_nxt = S_IDLE;
         end
         S_SERVE: begin
            if ((w_done_nxt | ~r_en_q) == 2'b11) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: w_state_nxt = continuous ? S_TRIGGER : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_en_q        <= 2'b00;
         r_done_flag   <= 2'b00;
         r_ptr         <= 1'b0;
         r_rvalid      <= 2'b00;
         r_last_addr   <= '0;
         r_timeout_err <= 1'b0;
         r_frame_count <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_rvalid    <= w_gnt;
         r_last_addr <= w_addr;

         if (r_state == S_TRIGGER) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_CAP) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (r_state == S_WAIT_CAP) begin
            if (cap_complete) begin
               r_frame_count <= r_frame_count + 16'd1;
               r_en_q        <= rd_en;
               r_done_flag   <= 2'b00;
            end else if (w_cnt_last) begin
               r_timeout_err <= 1'b1;
            end
         end

         if (r_state == S_SERVE) begin
            r_done_flag <= w_done_nxt;
         end

         // After serving reader 0 the tie goes to reader 1, and vice versa.
         if (w_gnt != 2'b00) begin
            r_ptr <= w_gnt[0];
         end
      end
   end

   assign cap_trigger    = (r_state == S_TRIGGER);
   assign frame_ready    = (r_state == S_SERVE);
   assign busy           = (r_state != S_IDLE);
   assign gnt            = w_gnt;
   assign bram_read_addr = w_addr;
   assign rvalid         = r_rvalid;
   assign rdata          = bram_read_data;
   assign timeout_err    = r_timeout_err;
   assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_binary_frame_scheduler.sv
// Bench for binary_frame_scheduler: directed scenarios followed by random traffic,
// all cycles compared against a transaction-level model of the scheduler and frame buffer.
module tb_binary_frame_scheduler;

   localparam int IMG_W = 16;
   localparam int IMG_H = 8;
   localparam int AW    = $clog2(IMG_W * IMG_H);
   localparam int TMO   = 50;
   localparam int DEPTH = IMG_W * IMG_H;

   localparam int P_IDLE  = 0;
   localparam int P_TRIG  = 1;
   localparam int P_WAIT  = 2;
   localparam int P_SERVE = 3;
   localparam int P_DRAIN = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          continuous;
   logic [1:0]    rd_en;
   logic          cap_trigger;
   logic          cap_complete;
   logic [AW-1:0] bram_read_addr;
   logic          bram_read_data;
   logic [1:0]    req;
   logic [AW-1:0] req_addr0;
   logic [AW-1:0] req_addr1;
   logic [1:0]    gnt;
   logic [1:0]    rvalid;
   logic          rdata;
   logic [1:0]    done;
   logic          frame_ready;
   logic          busy;
   logic          timeout_err;
   logic [15:0]   frame_count;

   binary_frame_scheduler #(
      .IMG_WIDTH  (IMG_W),
      .IMG_HEIGHT (IMG_H),
      .ADDR_W     (AW),
      .CAP_TIMEOUT(TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .continuous    (continuous),
      .rd_en         (rd_en),
      .cap_trigger   (cap_trigger),
      .cap_complete  (cap_complete),
      .bram_read_addr(bram_read_addr),
      .bram_read_data(bram_read_data),
      .req           (req),
      .req_addr0     (req_addr0),
      .req_addr1     (req_addr1),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .done          (done),
      .frame_ready   (frame_ready),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .frame_count   (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic mem [0:DEPTH-1];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: what phase we are in and what each reader still owes.
   int            m_phase;
   int            m_waited;
   logic [1:0]    m_en;
   logic [1:0]    m_fin;
   int            m_turn;
   int            m_frames;
   logic          m_err;
   logic [AW-1:0] m_last_addr;
   logic [1:0]    m_prev_gnt;
   logic          m_prev_bit;

   logic          e_trig, e_ready, e_busy, e_rdata;
   logic [1:0]    e_gnt, e_rvalid;
   logic [AW-1:0] e_addr;
   logic [AW-1:0] addr_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase     = P_IDLE;
      m_waited    = 0;
      m_en        = 2'b00;
      m_fin       = 2'b00;
      m_turn      = 0;
      m_frames    = 0;
      m_err       = 1'b0;
      m_last_addr = '0;
      m_prev_gnt  = 2'b00;
      m_prev_bit  = 1'b0;
   endtask

   task automatic model_eval();
      bit want0, want1;
      e_trig   = (m_phase == P_TRIG);
      e_ready  = (m_phase == P_SERVE);
      e_busy   = (m_phase != P_IDLE);
      e_rvalid = m_prev_gnt;
      e_rdata  = m_prev_bit;
      e_gnt    = 2'b00;
      if (m_phase == P_SERVE) begin
         want0 = req[0] && m_en[0] && !m_fin[0];
         want1 = req[1] && m_en[1] && !m_fin[1];
         if (want0 && want1) e_gnt = (m_turn == 0) ? 2'b01 : 2'b10;
         else if (want0)     e_gnt = 2'b01;
         else if (want1)     e_gnt = 2'b10;
      end
      if (e_gnt == 2'b01)      e_addr = req_addr0;
      else if (e_gnt == 2'b10) e_addr = req_addr1;
      else                     e_addr = m_last_addr;
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
         return;
      end
      m_prev_gnt  = e_gnt;
      m_last_addr = e_addr;
      m_prev_bit  = mem[e_addr];
      case (m_phase)
         P_IDLE: if (start) m_phase = P_TRIG;
         P_TRIG: begin
            m_phase  = P_WAIT;
            m_waited = 0;
         end
         P_WAIT: begin
            if (cap_complete) begin
               m_frames = (m_frames + 1) % 65536;
               m_en     = rd_en;
               m_fin    = 2'b00;
               m_phase  = P_SERVE;
            end else if (m_waited == TMO - 1) begin
               m_err   = 1'b1;
               m_phase = P_IDLE;
            end else begin
               m_waited++;
            end
         end
         P_SERVE: begin
            if (e_gnt == 2'b01) m_turn = 1;
            if (e_gnt == 2'b10) m_turn = 0;
            m_fin = m_fin | (done & m_en);
            if ((m_fin | ~m_en) == 2'b11) m_phase = P_DRAIN;
         end
         default: m_phase = continuous ? P_TRIG : P_IDLE;
      endcase
   endtask

   // One clock: compare every output against the model, then advance both.
   task automatic tick();
      #1;
      model_eval();
      chk("cap_trigger", cap_trigger, e_trig);
      chk("frame_ready", frame_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("gnt", gnt, e_gnt);
      chk("bram_read_addr", bram_read_addr, e_addr);
      chk("rvalid", rvalid, e_rvalid);
      if (e_rvalid != 2'b00) chk("rdata", rdata, e_rdata);
      chk("timeout_err", timeout_err, m_err);
      chk("frame_count", frame_count, m_frames[15:0]);
      addr_q = bram_read_addr;
      @(posedge clk);
      model_update();
      bram_read_data = mem[addr_q];
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 1'($urandom_range(0, 1));
      mem[0] = 1'b1;
      mem[5] = 1'b0;

      rst = 1'b1; start = 1'b0; continuous = 1'b0; rd_en = 2'b00;
      cap_complete = 1'b0; bram_read_data = 1'b0; req = 2'b00;
      req_addr0 = '0; req_addr1 = '0; done = 2'b00;
      @(posedge clk);
      @(negedge clk);
      model_reset();

      // Reset state, then first capture.
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_count", frame_count, 0);
      chk("rst_trigger", cap_trigger, 0);
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("first_trigger", cap_trigger, 1);
      chk("first_busy", busy, 1);
      tick();
      repeat (19) tick();
      cap_complete = 1'b1; rd_en = 2'b11;
      tick();
      cap_complete = 1'b0;
      chk("first_ready", frame_ready, 1);
      chk("first_count", frame_count, 1);

      // Both readers contend: grants alternate, data follows one cycle later.
      req = 2'b11; req_addr0 = AW'(0); req_addr1 = AW'(5);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         chk("rr_rvalid", rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_rdata", rdata, (k % 2 == 0) ? 1 : 0);
      end
      req = 2'b00; done = 2'b11;
      tick();
      done = 2'b00;
      chk("drain_ready", frame_ready, 0);
      chk("drain_busy", busy, 1);
      tick();
      chk("idle_busy", busy, 0);

      // Single reader, done with its last request.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cap_complete = 1'b1; rd_en = 2'b01;
      tick();
      cap_complete = 1'b0;
      req = 2'b01; req_addr0 = AW'(7); done = 2'b01;
      #1;
      chk("solo_gnt", gnt, 2'b01);
      chk("solo_addr", bram_read_addr, 7);
      tick();
      req = 2'b00; done = 2'b00;
      chk("solo_rvalid", rvalid, 2'b01);
      chk("solo_rdata", rdata, mem[7]);
      chk("solo_drain", frame_ready, 0);
      tick();
      chk("solo_idle", busy, 0);

      // Continuous mode re-triggers after drain; empty mask exits in one cycle.
      continuous = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cap_complete = 1'b1; rd_en = 2'b11;
      tick();
      cap_complete = 1'b0; done = 2'b11;
      tick();
      done = 2'b00;
      tick();
      chk("cont_retrigger", cap_trigger, 1);
      tick();
      cap_complete = 1'b1; rd_en = 2'b00;
      tick();
      cap_complete = 1'b0; continuous = 1'b0;
      chk("cont_count", frame_count, 4);
      tick();
      tick();
      chk("cont_idle", busy, 0);

      // Capture timeout; start during WAIT_CAP must not re-trigger.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < TMO; k++) begin
         start = (k == 10);
         tick();
         chk("tmo_no_trigger", cap_trigger, 0);
      end
      chk("tmo_err", timeout_err, 1);
      chk("tmo_idle", busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("tmo_restart", cap_trigger, 1);
      tick();
      cap_complete = 1'b1; rd_en = 2'b00;
      tick();
      cap_complete = 1'b0;
      tick();
      tick();
      chk("tmo_sticky", timeout_err, 1);

      // Reset while serving with both requests high.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cap_complete = 1'b1; rd_en = 2'b11;
      tick();
      cap_complete = 1'b0; req = 2'b11;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_gnt", gnt, 0);
      chk("rst_mid_rvalid", rvalid, 0);
      chk("rst_mid_count", frame_count, 0);
      chk("rst_mid_err", timeout_err, 0);

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 599) == 0);
         start        = ($urandom_range(0, 7) == 0);
         continuous   = ($urandom_range(0, 3) == 0);
         cap_complete = ($urandom_range(0, 24) == 0);
         rd_en        = 2'($urandom_range(0, 3));
         req          = 2'($urandom_range(0, 3));
         req_addr0    = AW'($urandom_range(0, DEPTH - 1));
         req_addr1    = AW'($urandom_range(0, DEPTH - 1));
         done         = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
